// File: rtl/mioc_xnor_serial_cmp_if.sv
// rtl/mioc_xnor_serial_cmp_if.sv - handshake bundle between XNOR bit source, serial comparator and result sink
interface mioc_xnor_serial_cmp_if;
  logic       start;
  logic       in_valid;
  logic       in_eq;
  logic       in_ready;
  logic       out_ready;
  logic       done_valid;
  logic       match;
  logic [7:0] mismatch_cnt;

  modport master (
    output start, in_valid, in_eq, out_ready,
    input  in_ready, done_valid, match, mismatch_cnt
  );

  modport slave (
    input  start, in_valid, in_eq, out_ready,
    output in_ready, done_valid, match, mismatch_cnt
  );
endinterface

// File: rtl/mioc_xnor_serial_cmp.sv
// rtl/mioc_xnor_serial_cmp.sv - serial AND-reduction of WIDTH XNOR bits; MIOC_MISMATCH_CNT_EN adds a zero-bit counter
module mioc_xnor_serial_cmp #(
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  mioc_xnor_serial_cmp_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] LAST_BIT = 8'(WIDTH - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_bit_cnt;
  logic       r_acc;
  logic [7:0] w_mcnt;
  logic       w_xfer;
  logic       w_clear;

  assign w_xfer  = (r_state == SHIFT) && bus.in_valid;
  assign w_clear = (r_state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (w_xfer && (r_bit_cnt == LAST_BIT)) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit counter stops at WIDTH after the last transfer; it is only reloaded by the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_acc     <= 1'b0;
    end else if (w_clear) begin
      r_bit_cnt <= '0;
      r_acc     <= 1'b1;
    end else if (w_xfer) begin
      r_bit_cnt <= r_bit_cnt + 8'd1;
      r_acc     <= r_acc & bus.in_eq;
    end
  end

`ifdef MIOC_MISMATCH_CNT_EN
  logic [7:0] r_mcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt <= '0;
    end else if (w_clear) begin
      r_mcnt <= '0;
    end else if (w_xfer && !bus.in_eq && (r_mcnt != 8'hFF)) begin
      r_mcnt <= r_mcnt + 8'd1;
    end
  end

  assign w_mcnt = r_mcnt;
`else
  assign w_mcnt = '0;
`endif

  // Results are gated by state so they read zero outside DONE, including during reset.
  assign bus.in_ready     = (r_state == SHIFT);
  assign bus.done_valid   = (r_state == DONE);
  assign bus.match        = (r_state == DONE) && r_acc;
  assign bus.mismatch_cnt = (r_state == DONE) ? w_mcnt : 8'd0;

endmodule

// File: tb/tb_mioc_xnor_serial_cmp.sv
// tb/tb_mioc_xnor_serial_cmp.sv - self-checking bench for mioc_xnor_serial_cmp (WIDTH=8 and WIDTH=1 instances)
module tb_mioc_xnor_serial_cmp;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mioc_xnor_serial_cmp_if bus_a ();
  mioc_xnor_serial_cmp_if bus_b ();

  mioc_xnor_serial_cmp #(.WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mioc_xnor_serial_cmp #(.WIDTH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;
    int         gap;
    logic       exp_match;
    int         exp_cnt_en;
  } vec_t;

  vec_t vecs[5];

  function automatic int exp_cnt(input int cnt_en);
`ifdef MIOC_MISMATCH_CNT_EN
    return (cnt_en > 255) ? 255 : cnt_en;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic feed_a(input string tag, input logic [7:0] bits, input int gap, input bit rand_gap);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = rand_gap ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
      for (int k = 0; k < g; k++) begin
        bus_a.in_valid = 1'b0;
        bus_a.in_eq    = 1'($urandom);
        tick();
      end
      chk({tag, "_busy_dv"}, bus_a.done_valid, 0);
      chk({tag, "_busy_rdy"}, bus_a.in_ready, 1);
      bus_a.in_valid = 1'b1;
      bus_a.in_eq    = bits[i];
      tick();
    end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic result_a(input string tag, input logic m, input int c);
    chk({tag, "_dv"}, bus_a.done_valid, 1);
    chk({tag, "_match"}, bus_a.match, m);
    chk({tag, "_cnt"}, bus_a.mismatch_cnt, c);
    chk({tag, "_rdy"}, bus_a.in_ready, 0);
  endtask

  task automatic release_a(input string tag);
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    chk({tag, "_rel_dv"}, bus_a.done_valid, 0);
    chk({tag, "_rel_match"}, bus_a.match, 0);
    chk({tag, "_rel_cnt"}, bus_a.mismatch_cnt, 0);
  endtask

  initial begin
    logic [7:0] rb;
    int         zeros;
    logic [7:0] hold_cnt;

    total = 0;
    bad   = 0;
    vecs[0] = '{bits: 8'hFF,        gap: 0, exp_match: 1'b1, exp_cnt_en: 0};
    vecs[1] = '{bits: 8'b1011_1011, gap: 0, exp_match: 1'b0, exp_cnt_en: 2};
    vecs[2] = '{bits: 8'hFF,        gap: 2, exp_match: 1'b1, exp_cnt_en: 0};
    vecs[3] = '{bits: 8'h00,        gap: 1, exp_match: 1'b0, exp_cnt_en: 8};
    vecs[4] = '{bits: 8'h7F,        gap: 0, exp_match: 1'b0, exp_cnt_en: 1};

    bus_a.start = 0; bus_a.in_valid = 0; bus_a.in_eq = 0; bus_a.out_ready = 0;
    bus_b.start = 0; bus_b.in_valid = 0; bus_b.in_eq = 0; bus_b.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", bus_a.in_ready, 0);
    chk("rst_dv", bus_a.done_valid, 0);
    chk("rst_match", bus_a.match, 0);
    chk("rst_cnt", bus_a.mismatch_cnt, 0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores in_valid without start
    bus_a.in_valid = 1'b1;
    bus_a.in_eq    = 1'b0;
    repeat (3) tick();
    bus_a.in_valid = 1'b0;
    chk("idle_rdy", bus_a.in_ready, 0);
    chk("idle_dv", bus_a.done_valid, 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_a();
      feed_a(tag, vecs[i].bits, vecs[i].gap, 1'b0);
      result_a(tag, vecs[i].exp_match, exp_cnt(vecs[i].exp_cnt_en));
      release_a(tag);
    end

    for (int n = 0; n < 20; n++) begin
      string tag;
      tag = $sformatf("rnd%0d", n);
      rb = 8'($urandom);
      if (n % 4 == 0) rb = 8'hFF;
      zeros = 0;
      for (int b = 0; b < 8; b++) if (rb[b] == 1'b0) zeros++;
      start_a();
      feed_a(tag, rb, 0, 1'b1);
      result_a(tag, (zeros == 0), exp_cnt(zeros));
      release_a(tag);
    end

    // DONE held with out_ready low while start and in_valid are pulsed
    start_a();
    feed_a("hold", 8'b1011_1011, 0, 1'b0);
    hold_cnt = 8'(exp_cnt(2));
    for (int c = 0; c < 5; c++) begin
      bus_a.start    = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_eq    = 1'($urandom);
      tick();
      result_a($sformatf("hold%0d", c), 1'b0, int'(hold_cnt));
    end
    bus_a.in_valid  = 1'b0;
    bus_a.start     = 1'b1;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.start     = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("hold_exit_dv", bus_a.done_valid, 0);
    chk("hold_exit_rdy", bus_a.in_ready, 0);
    tick();
    chk("hold_exit_rdy2", bus_a.in_ready, 0);

    // async reset after 4 transfers of zero bits
    start_a();
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_eq    = 1'b0;
      tick();
    end
    bus_a.in_valid = 1'b0;
    chk("pre_rst_rdy", bus_a.in_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", bus_a.in_ready, 0);
    chk("arst_dv", bus_a.done_valid, 0);
    chk("arst_match", bus_a.match, 0);
    chk("arst_cnt", bus_a.mismatch_cnt, 0);
    tick();
    rst_n = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_eq    = 1'b1;
    repeat (10) tick();
    bus_a.in_valid = 1'b0;
    chk("post_rst_idle_rdy", bus_a.in_ready, 0);
    chk("post_rst_idle_dv", bus_a.done_valid, 0);
    start_a();
    feed_a("post_rst", 8'hFF, 0, 1'b0);
    result_a("post_rst", 1'b1, 0);
    release_a("post_rst");

    // WIDTH=1 instance
    for (int v = 0; v < 2; v++) begin
      string tag;
      tag = $sformatf("w1_%0d", v);
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      chk({tag, "_rdy"}, bus_b.in_ready, 1);
      bus_b.in_valid = 1'b1;
      bus_b.in_eq    = (v == 1);
      tick();
      bus_b.in_valid = 1'b0;
      chk({tag, "_dv"}, bus_b.done_valid, 1);
      chk({tag, "_match"}, bus_b.match, (v == 1));
      chk({tag, "_cnt"}, bus_b.mismatch_cnt, exp_cnt((v == 1) ? 0 : 1));
      bus_b.out_ready = 1'b1;
      tick();
      bus_b.out_ready = 1'b0;
      chk({tag, "_rel_dv"}, bus_b.done_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mioc_xnor_serial_cmp.md
MIOC_XNOR_SERIAL_CMP -- requirements
Module: mioc_xnor_serial_cmp

Interface
REQ-001 Parameter WIDTH, default 8, is the number of XNOR bit results per compare word (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin a new compare word.
REQ-005 in_valid  input  1  upstream XNOR result on in_eq is valid this cycle.
REQ-006 in_eq  input  1  per-bit XNOR output (1 = bits equal, 0 = bits differ).
REQ-007 in_ready  output  1  block accepts in_eq this cycle.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 done_valid  output  1  compare result valid.
REQ-010 match  output  1  1 = all WIDTH bits equal; qualified by done_valid.
REQ-011 mismatch_cnt  output  8  count of in_eq==0 bits in the word; qualified by done_valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE: in_ready=0 and done_valid=0; in_valid is ignored; start=1 moves to SHIFT and clears bit counter, accumulator (set to 1) and mismatch counter.
REQ-014 In SHIFT: in_ready=1; a transfer occurs only on in_valid&in_ready in the same cycle.
REQ-015 On each transfer: accumulator <= accumulator AND in_eq; bit counter increments by 1.
REQ-016 On the transfer with bit counter == WIDTH-1: FSM moves to DONE; the counter does not wrap into a second word.
REQ-017 Cycles with in_valid=0 in SHIFT SHALL leave all state unchanged (gaps allowed, any length).
REQ-018 In DONE: done_valid=1, in_ready=0; match equals the accumulator; match and mismatch_cnt SHALL stay stable until handshake.
REQ-019 done_valid SHALL rise on the clock edge of the final transfer (visible the following cycle); latency from final accepted bit = 1 cycle.
REQ-020 In DONE, out_ready=1 returns the FSM to IDLE on that edge; done_valid drops the next cycle.
REQ-021 start SHALL be ignored in SHIFT and DONE, including the cycle DONE exits via out_ready.
REQ-022 match and mismatch_cnt SHALL read 0 whenever done_valid=0.
REQ-023 WIDTH=1: one transfer moves SHIFT to DONE directly.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, clear all counters, and drive in_ready=0, done_valid=0, match=0, mismatch_cnt=0.
REQ-025 Reset asserted mid-word (SHIFT or DONE) SHALL discard the partial word; no result is produced for it.
REQ-026 After rst_n deassertion the block SHALL wait in IDLE for start.

Configuration
REQ-027 Macro MIOC_MISMATCH_CNT_EN SHALL gate the mismatch counter.
REQ-028 With MIOC_MISMATCH_CNT_EN defined: mismatch_cnt increments on each transfer with in_eq=0, saturating at 255.
REQ-029 Without MIOC_MISMATCH_CNT_EN: the counter is not built, mismatch_cnt is tied to 0, and all other behaviour is identical.

Verification
REQ-030 WIDTH=8: start, then 8 transfers of in_eq=1 -> done_valid=1 in the cycle after the 8th transfer, match=1, mismatch_cnt=0.
REQ-031 WIDTH=8: bit sequence 1,1,0,1,1,1,0,1 -> match=0; mismatch_cnt=2 with the macro, 0 without it.
REQ-032 in_valid toggling 1,0,0,1,... over 8 accepted bits -> same result as back-to-back input; done_valid only after the 8th accepted bit.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while pulsing start and in_valid -> done_valid, match and mismatch_cnt stay stable, in_ready=0, no new word starts.
REQ-034 rst_n pulsed low after 4 transfers -> all outputs 0 immediately, without waiting for a clock edge; a following start plus 8 in_eq=1 transfers gives match=1, mismatch_cnt=0.
REQ-035 WIDTH=1: start, then one transfer with in_eq=0 -> done_valid next cycle, match=0, mismatch_cnt=1 with the macro.
